mandel_engine_scheduler: RTL and testbench
==========================================

Name: mandel_engine_scheduler

Overview:
- Frame-level scheduler that shares the pixel workload of one frame across NUM_ENGINES mandelbrot engines.
- Issues pixel coordinates round-robin and collects each engine's 4-bit iteration result.
- Retires results to the framebuffer write port strictly in raster order, using the write_data/wrote_data handshake.
- Sits between the top-level render FSM (start/done) and the engine array plus the VGA framebuffer.

Parameters:
NUM_ENGINES, 2, number of engine slots (1..8)
WIDTH, 400, pixels per row
HEIGHT, 300, rows per frame
PIXW, 9, width of the x/y coordinate outputs (must hold max(WIDTH,HEIGHT)-1)

Ports:
clk  in  1  clock
combined_rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin a frame; ignored while busy=1
busy  out  1  high from accepted start until the done pulse
done  out  1  one-cycle pulse after the last pixel is accepted by the framebuffer
eng_run  out  NUM_ENGINES  one-hot, one-cycle issue pulse to engine i
issue_x  out  PIXW  pixel column; valid only in a cycle where eng_run!=0
issue_y  out  PIXW  pixel row; valid only in a cycle where eng_run!=0
eng_running  in  NUM_ENGINES  per-engine busy flag
eng_ctr  in  4*NUM_ENGINES  engine i result on bits [4i+3:4i]; valid when eng_running[i] falls
reset_write_ptr  out  1  one-cycle pulse at frame start
write_data  out  1  one-cycle pulse: present write_value to the framebuffer
write_value  out  4  pixel result
wrote_data  in  1  framebuffer accepted the outstanding write

Behaviour:
- Reset (asynchronous, any time, including mid-frame): all outputs 0; top FSM to IDLE; all slots FREE; counters and pointers 0; outstanding write cleared.
- Top FSM:
  - IDLE: on start, go to CLEAR.
  - CLEAR: reset_write_ptr=1 for exactly this one cycle; go to RUN.
  - RUN: issue and retire run concurrently. When retire_cnt reaches WIDTH*HEIGHT, pulse done for 1 cycle and go to IDLE.
- busy=1 in CLEAR and RUN. Counters are clog2(WIDTH*HEIGHT+1) bits wide.
- Per-slot FSM, slots 0..NUM_ENGINES-1:
  - FREE -> ISSUED when the slot is issued.
  - ISSUED -> BUSY when eng_running[i]=1.
  - BUSY -> DONE when eng_running[i]=0; eng_ctr[i] is captured into the slot result register in that same cycle.
  - DONE -> FREE when its write is accepted.
  - eng_running changes in FREE or DONE are ignored.
- Issue rule:
  - Issue happens in RUN when slot[ip]==FREE (registered state) and issue_cnt < WIDTH*HEIGHT.
  - At most one issue per cycle.
  - On issue: eng_run[ip]=1 for 1 cycle; issue_x/issue_y = current (x,y).
  - After issue: x++, wrapping at WIDTH-1 to 0 with y++; ip advances modulo NUM_ENGINES; issue_cnt++.
  - If slot[ip] is not FREE, issue stalls; ip does not skip ahead.
- Retire rule:
  - Retire happens when slot[rp]==DONE and no write is outstanding.
  - write_data=1 for 1 cycle with write_value = result[rp]; set outstanding.
  - On wrote_data while outstanding: clear outstanding; slot[rp]=FREE; rp advances modulo NUM_ENGINES; retire_cnt++.
  - wrote_data while not outstanding is ignored.
  - A new write_data may go out no earlier than the cycle after wrote_data.
- Ordering: ip and rp traverse slots in the same order, so framebuffer writes occur in raster order regardless of engine finish order.
- Simultaneous events:
  - A slot freed by wrote_data can be reissued no earlier than the next cycle.
  - Capture and retire of different slots may happen in the same cycle.
  - start coincident with done is ignored (FSM is still busy that cycle).
- Latency:
  - First issue occurs 2 cycles after start (start -> CLEAR -> RUN issues slot 0).
  - A result is written at the earliest the cycle after its DONE transition.
- eng_run and write_data are never asserted outside RUN.

Test Plan:
- NUM_ENGINES=1, WIDTH=4, HEIGHT=2, engine model returns x+y after a 3-cycle run, framebuffer acks 1 cycle after each write -> 8 writes with values 0,1,2,3,1,2,3,4; exactly one reset_write_ptr pulse; one done pulse; busy low afterwards.
- NUM_ENGINES=2, engine 0 takes 10 cycles and engine 1 takes 2 cycles -> pixel 1's write is held until pixel 0 is written; write order stays raster 0..7; engine 1 is not reissued before its result retires.
- Framebuffer withholds wrote_data for 20 cycles -> write_data is pulsed once and not repeated; no further issues once all slots are DONE; progress resumes on ack.
- start pulsed mid-frame and again in the done cycle -> both ignored; no extra reset_write_ptr; frame count stays 1.
- Assert combined_rst_n low mid-frame, then release and start -> all outputs 0 during reset; new frame begins at (0,0) with a reset_write_ptr pulse.
- Spurious wrote_data with nothing outstanding, plus eng_running toggling on an unissued slot -> no state change; retire_cnt unchanged.

Source files
------------

// File: rtl/mandel_engine_scheduler.sv
// Frame scheduler: hands pixels round-robin to NUM_ENGINES mandelbrot engines and
// retires their 4-bit results to the framebuffer strictly in raster order.
module mandel_engine_scheduler #(
   parameter int NUM_ENGINES = 2,
   parameter int WIDTH       = 400,
   parameter int HEIGHT      = 300,
   parameter int PIXW        = 9
) (
   input  logic                     clk,
   input  logic                     combined_rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_ENGINES-1:0]   eng_run,
   output logic [PIXW-1:0]          issue_x,
   output logic [PIXW-1:0]          issue_y,
   input  logic [NUM_ENGINES-1:0]   eng_running,
   input  logic [4*NUM_ENGINES-1:0] eng_ctr,
   output logic                     reset_write_ptr,
   output logic                     write_data,
   output logic [3:0]               write_value,
   input  logic                     wrote_data
);

   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CNTW  = $clog2(TOTAL + 1);
   localparam int IPW   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

   localparam logic [CNTW-1:0] TOTAL_C   = CNTW'(TOTAL);
   localparam logic [IPW-1:0]  LAST_SLOT = IPW'(NUM_ENGINES - 1);
   localparam logic [PIXW-1:0] LAST_X    = PIXW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN
   } top_state_t;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_ISSUED,
      SLOT_BUSY,
      SLOT_DONE
   } slot_state_t;

   top_state_t  state_q, state_d;
   slot_state_t slot_q [NUM_ENGINES];
   slot_state_t slot_d [NUM_ENGINES];
   logic [3:0]  result_q [NUM_ENGINES];

   logic [IPW-1:0]  ip_q, rp_q;
   logic [PIXW-1:0] x_q, y_q;
   logic [CNTW-1:0] issue_cnt_q, retire_cnt_q;
   logic            outstanding_q;

   logic issue_fire;
   logic retire_fire;
   logic ack_fire;
   logic frame_done;

   // Issue and retire look only at registered slot state, so a slot freed by an
   // ack becomes issuable the following cycle.
   always_comb begin
      issue_fire  = (state_q == RUN) && (slot_q[ip_q] == SLOT_FREE) && (issue_cnt_q < TOTAL_C);
      retire_fire = (state_q == RUN) && (slot_q[rp_q] == SLOT_DONE) && !outstanding_q;
      ack_fire    = wrote_data && outstanding_q;
      frame_done  = (state_q == RUN) && (retire_cnt_q == TOTAL_C);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = RUN;
         RUN:     if (frame_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge combined_rst_n) begin
      if (!combined_rst_n) state_q <= IDLE;
      else                 state_q <= state_d;
   end

   always_comb begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
         slot_d[i] = slot_q[i];
         case (slot_q[i])
            SLOT_FREE:   if (issue_fire && (ip_q == IPW'(i))) slot_d[i] = SLOT_ISSUED;
            SLOT_ISSUED: if (eng_running[i]) slot_d[i] = SLOT_BUSY;
            SLOT_BUSY:   if (!eng_running[i]) slot_d[i] = SLOT_DONE;
            SLOT_DONE:   if (ack_fire && (rp_q == IPW'(i))) slot_d[i] = SLOT_FREE;
            default:     slot_d[i] = SLOT_FREE;
         endcase
      end
   end

   // The result is captured on the falling edge of eng_running, the only cycle
   // in which eng_ctr is guaranteed valid.
   always_ff @(posedge clk or negedge combined_rst_n) begin
      if (!combined_rst_n) begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            slot_q[i]   <= SLOT_FREE;
            result_q[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            slot_q[i] <= slot_d[i];
            if ((slot_q[i] == SLOT_BUSY) && !eng_running[i]) result_q[i] <= eng_ctr[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge combined_rst_n) begin
      if (!combined_rst_n) begin
         ip_q          <= '0;
         rp_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         issue_cnt_q   <= '0;
         retire_cnt_q  <= '0;
         outstanding_q <= 1'b0;
      end else if (state_q == CLEAR) begin
         ip_q          <= '0;
         rp_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         issue_cnt_q   <= '0;
         retire_cnt_q  <= '0;
         outstanding_q <= 1'b0;
      end else begin
         if (issue_fire) begin
            if (x_q == LAST_X) begin
               x_q <= '0;
               y_q <= y_q + PIXW'(1);
            end else begin
               x_q <= x_q + PIXW'(1);
            end
            ip_q        <= (ip_q == LAST_SLOT) ? '0 : ip_q + IPW'(1);
            issue_cnt_q <= issue_cnt_q + CNTW'(1);
         end
         if (retire_fire) outstanding_q <= 1'b1;
         if (ack_fire) begin
            outstanding_q <= 1'b0;
            rp_q          <= (rp_q == LAST_SLOT) ? '0 : rp_q + IPW'(1);
            retire_cnt_q  <= retire_cnt_q + CNTW'(1);
         end
      end
   end

   always_comb begin
      eng_run = '0;
      if (issue_fire) eng_run[ip_q] = 1'b1;
   end

   assign busy            = (state_q != IDLE);
   assign done            = frame_done;
   assign reset_write_ptr = (state_q == CLEAR);
   assign write_data      = retire_fire;
   assign write_value     = result_q[rp_q];
   assign issue_x         = x_q;
   assign issue_y         = y_q;

endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Self-checking bench: behavioural engines and framebuffer with random latencies,
// checked against a raster-order model of which pixel each issue and write must carry.
module tb_mandel_engine_scheduler;

   localparam int NE    = 2;
   localparam int W     = 4;
   localparam int H     = 3;
   localparam int PW    = 3;
   localparam int TOTAL = W * H;

   logic            clk = 1'b0;
   logic            combined_rst_n;
   logic            start;
   logic            busy;
   logic            done;
   logic [NE-1:0]   eng_run;
   logic [PW-1:0]   issue_x;
   logic [PW-1:0]   issue_y;
   logic [NE-1:0]   eng_running = '0;
   logic [4*NE-1:0] eng_ctr = '0;
   logic            reset_write_ptr;
   logic            write_data;
   logic [3:0]      write_value;
   logic            wrote_data = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   int         eng_left   [NE];
   bit         eng_active [NE];
   bit         eng_glitch [NE];
   logic [3:0] eng_res    [NE];
   bit         slot_owed  [NE];
   int         fixed_dur  [NE];
   int         dur_min = 2;
   int         dur_max = 6;
   int         ack_delay = 0;
   bit         ack_pending = 1'b0;
   bit         ack_is_real = 1'b0;
   int         ack_wait = 0;
   bit         glitch_en = 1'b0;
   bit         spurious_en = 1'b0;
   int         issue_idx = 0;
   int         write_idx = 0;
   int         ack_idx = 0;
   int         rwp_count = 0;
   int         done_count = 0;
   int         salt = 0;
   bit         just_done;
   int         exp_rwp = 0;
   int         exp_done = 0;

   mandel_engine_scheduler #(
      .NUM_ENGINES(NE),
      .WIDTH(W),
      .HEIGHT(H),
      .PIXW(PW)
   ) dut (
      .clk(clk),
      .combined_rst_n(combined_rst_n),
      .start(start),
      .busy(busy),
      .done(done),
      .eng_run(eng_run),
      .issue_x(issue_x),
      .issue_y(issue_y),
      .eng_running(eng_running),
      .eng_ctr(eng_ctr),
      .reset_write_ptr(reset_write_ptr),
      .write_data(write_data),
      .write_value(write_value),
      .wrote_data(wrote_data)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] pix_val(input int x, input int y, input int s);
      int v;
      v = x * 5 + y * 3 + s;
      return v[3:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Engines, framebuffer and raster-order scoreboard all live on the falling edge,
   // where the DUT's registered outputs are stable.
   always @(negedge clk) begin
      int e;
      logic [3:0] exp_v;
      if (!combined_rst_n) begin
         for (int i = 0; i < NE; i++) begin
            eng_active[i] = 1'b0;
            eng_glitch[i] = 1'b0;
            eng_left[i]   = 0;
            slot_owed[i]  = 1'b0;
         end
         eng_running = '0;
         eng_ctr     = '0;
         wrote_data  = 1'b0;
         ack_is_real = 1'b0;
         ack_pending = 1'b0;
         ack_wait    = 0;
         issue_idx   = 0;
         write_idx   = 0;
         ack_idx     = 0;
      end else begin
         just_done = 1'b0;
         if (reset_write_ptr) begin
            rwp_count++;
            issue_idx = 0;
            write_idx = 0;
            ack_idx   = 0;
            for (int i = 0; i < NE; i++) slot_owed[i] = 1'b0;
         end
         if (wrote_data) begin
            if (ack_is_real) begin
               slot_owed[ack_idx % NE] = 1'b0;
               ack_idx++;
               just_done = (ack_idx == TOTAL);
            end
            wrote_data  = 1'b0;
            ack_is_real = 1'b0;
         end
         if (ack_pending) begin
            ack_wait--;
            if (ack_wait == 0) begin
               wrote_data  = 1'b1;
               ack_is_real = 1'b1;
               ack_pending = 1'b0;
            end
         end else if (spurious_en && ($urandom_range(0, 5) == 0)) begin
            wrote_data = 1'b1;
         end
         for (int i = 0; i < NE; i++) begin
            if (eng_active[i]) begin
               eng_left[i]--;
               if (eng_left[i] == 0) begin
                  eng_active[i]     = 1'b0;
                  eng_running[i]    = 1'b0;
                  eng_ctr[4*i +: 4] = eng_res[i];
               end else begin
                  eng_ctr[4*i +: 4] = 4'($urandom);
               end
            end else if (eng_glitch[i]) begin
               eng_glitch[i]     = 1'b0;
               eng_running[i]    = 1'b0;
               eng_ctr[4*i +: 4] = 4'($urandom);
            end else begin
               eng_ctr[4*i +: 4] = 4'($urandom);
               if (glitch_en && ($urandom_range(0, 3) == 0)) begin
                  eng_glitch[i]  = 1'b1;
                  eng_running[i] = 1'b1;
               end
            end
         end
         if (eng_run != '0) begin
            e = 0;
            for (int i = 0; i < NE; i++) if (eng_run[i]) e = i;
            vectors++;
            assert ($onehot(eng_run) && busy && !reset_write_ptr) else begin
               miscompares++;
               $error("[TB] FAIL issue_context: eng_run=%b busy=%b rwp=%b, required one-hot in RUN", eng_run, busy, reset_write_ptr);
            end
            vectors++;
            assert ((e == issue_idx % NE) && (issue_idx < TOTAL)) else begin
               miscompares++;
               $error("[TB] FAIL issue_engine: observed engine %0d for issue %0d, expected engine %0d", e, issue_idx, issue_idx % NE);
            end
            vectors++;
            assert ((issue_x === PW'(issue_idx % W)) && (issue_y === PW'(issue_idx / W))) else begin
               miscompares++;
               $error("[TB] FAIL issue_xy: observed (%0d,%0d) expected (%0d,%0d)", issue_x, issue_y, issue_idx % W, issue_idx / W);
            end
            vectors++;
            assert (!slot_owed[e]) else begin
               miscompares++;
               $error("[TB] FAIL reissue: engine %0d observed reissued, expected held until its result retires", e);
            end
            slot_owed[e]      = 1'b1;
            issue_idx++;
            eng_active[e]     = 1'b1;
            eng_glitch[e]     = 1'b0;
            eng_left[e]       = (fixed_dur[e] != 0) ? fixed_dur[e] : int'($urandom_range(dur_min, dur_max));
            eng_res[e]        = pix_val(int'(issue_x), int'(issue_y), salt);
            eng_running[e]    = 1'b1;
            eng_ctr[4*e +: 4] = 4'($urandom);
         end
         if (write_data) begin
            exp_v = pix_val(write_idx % W, write_idx / W, salt);
            vectors++;
            assert (busy && !reset_write_ptr && !ack_pending && !(wrote_data && ack_is_real) && (write_idx < TOTAL)) else begin
               miscompares++;
               $error("[TB] FAIL write_protocol: write %0d observed while outstanding=%b busy=%b, expected none", write_idx, ack_pending, busy);
            end
            vectors++;
            assert (write_value === exp_v) else begin
               miscompares++;
               $error("[TB] FAIL write_value: pixel %0d observed %0d expected %0d", write_idx, write_value, exp_v);
            end
            write_idx++;
            ack_pending = 1'b1;
            ack_wait    = (ack_delay != 0) ? ack_delay : int'($urandom_range(1, 3));
         end
         vectors++;
         assert (done === just_done) else begin
            miscompares++;
            $error("[TB] FAIL done_timing: observed %b expected %b (acks=%0d)", done, just_done, ack_idx);
         end
         if (done) done_count++;
      end
   end

   // Pulse start and confirm the CLEAR cycle and the first issue of slot 0 at (0,0).
   task automatic applyStimulus();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("clear_rwp", 32'(reset_write_ptr), 32'd1);
      checkOutput("clear_busy", 32'(busy), 32'd1);
      checkOutput("clear_no_issue", 32'(eng_run), 32'd0);
      @(negedge clk);
      checkOutput("first_issue_run", 32'(eng_run), 32'd1);
      checkOutput("first_issue_xy", 32'({issue_x, issue_y}), 32'd0);
      checkOutput("rwp_single", 32'(reset_write_ptr), 32'd0);
      exp_rwp++;
   endtask

   task automatic waitDone(input int budget, input int mid_start_at, input bit start_on_done);
      int  n = 0;
      bit  seen = 1'b0;
      while ((n < budget) && !seen) begin
         @(negedge clk);
         n++;
         start = (n == mid_start_at);
         if (done) begin
            seen  = 1'b1;
            start = start_on_done;
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      exp_done++;
      @(negedge clk);
      start = 1'b0;
      checkOutput("idle_after_done", 32'({busy, reset_write_ptr, eng_run, write_data}), 32'd0);
      @(negedge clk);
      checkOutput("still_idle", 32'({busy, reset_write_ptr, eng_run, write_data}), 32'd0);
      #1;
      checkOutput("rwp_count", 32'(rwp_count), 32'(exp_rwp));
      checkOutput("done_count", 32'(done_count), 32'(exp_done));
      checkOutput("acks_in_frame", 32'(ack_idx), 32'(TOTAL));
   endtask

   initial begin
      int n;
      bit seen;
      combined_rst_n = 1'b0;
      start          = 1'b0;
      for (int i = 0; i < NE; i++) fixed_dur[i] = 0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'({busy, done, reset_write_ptr, write_data, eng_run, issue_x, issue_y, write_value}), 32'd0);
      #2 combined_rst_n = 1'b1;

      $display("[TB] frame 1: random latencies, start mid-frame and in done cycle");
      salt = $urandom_range(0, 15);
      applyStimulus();
      waitDone(2000, 6, 1'b1);

      $display("[TB] frame 2: slow engine 0, fast engine 1");
      fixed_dur[0] = 10;
      fixed_dur[1] = 2;
      ack_delay    = 1;
      salt         = $urandom_range(0, 15);
      applyStimulus();
      waitDone(2000, 0, 1'b0);

      $display("[TB] frame 3: framebuffer withholds ack for 20 cycles");
      fixed_dur[0] = 2;
      fixed_dur[1] = 2;
      ack_delay    = 20;
      salt         = $urandom_range(0, 15);
      applyStimulus();
      n    = 0;
      seen = 1'b0;
      while ((n < 100) && !seen) begin
         @(negedge clk);
         n++;
         seen = write_data;
      end
      checkOutput("first_write_seen", 32'(seen), 32'd1);
      repeat (18) begin
         @(negedge clk);
         checkOutput("hold_quiet", 32'({eng_run, write_data}), 32'd0);
      end
      waitDone(2000, 0, 1'b0);

      $display("[TB] frame 4: spurious acks and eng_running glitches");
      fixed_dur[0] = 0;
      fixed_dur[1] = 0;
      ack_delay    = 0;
      glitch_en    = 1'b1;
      spurious_en  = 1'b1;
      salt         = $urandom_range(0, 15);
      applyStimulus();
      waitDone(2000, 0, 1'b0);
      glitch_en   = 1'b0;
      spurious_en = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] frame 5: reset asserted mid-frame");
      salt = $urandom_range(0, 15);
      applyStimulus();
      repeat (15) @(negedge clk);
      #2 combined_rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_outputs", 32'({busy, done, reset_write_ptr, write_data, eng_run, issue_x, issue_y, write_value}), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_hold_outputs", 32'({busy, done, reset_write_ptr, write_data, eng_run, issue_x, issue_y, write_value}), 32'd0);
      #1 combined_rst_n = 1'b1;

      $display("[TB] frame 6: fresh frame after reset");
      salt = $urandom_range(0, 15);
      applyStimulus();
      waitDone(2000, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation observed still running, expected to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
